not_not_judge: RTL and testbench

- Response-side counterpart to the Not-Not challenge generator.
- Accepts one challenge per round: the expected 4-bit colour mask that the generator shows on LEDR.
- Samples the player's answer from the switches when the submit key is pressed, or declares a miss when the round timer expires.
- Keeps score and lives, and signals game over.

---
 rtl/not_not_pkg.sv | 7 +
 rtl/not_not_judge_key_edge_sync.sv | 27 ++
 rtl/not_not_judge.sv | 146 ++++++++++++++
 tb/tb_not_not_judge.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/not_not_pkg.sv
// not_not_pkg: shared types and defaults for the Not-Not challenge generator and judge.
package not_not_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, JUDGE, OVER} state_t;
    localparam int COLOR_W            = 4;
    localparam int DEF_TIMEOUT_CYCLES = 50000000;
    localparam int DEF_LIVES          = 3;
endpackage

// File: rtl/not_not_judge_key_edge_sync.sv
// key_edge_sync: 2-flop synchroniser plus registered falling-edge detect for an active-low KEY.
module key_edge_sync (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_n,
    output logic press_evt
);
    logic [2:0] sync_q, sync_d;
    logic       press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[1:0], key_n};
        press_d = sync_q[2] & ~sync_q[1];
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= 3'b111;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            press_q <= press_d;
        end
    end

    assign press_evt = press_q;
endmodule

// File: rtl/not_not_judge.sv
// not_not_judge: judges player answers against challenges, keeping score, lives and game over.
// Optional NOT_NOT_SPEEDUP_EN shortens the round limit after every correct answer.
module not_not_judge
    import not_not_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SCORE_W        = 8,
    parameter int LIVES          = DEF_LIVES
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               round_valid,
    output logic               round_ready,
    input  logic [COLOR_W-1:0] expected,
    input  logic [COLOR_W-1:0] answer,
    input  logic               submit_n,
    output logic               result_valid,
    output logic               result_correct,
    output logic               result_timeout,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives_left,
    output logic               game_over
);
    localparam int            TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST       = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d, lim_m1;
    logic [COLOR_W-1:0] exp_q, exp_d, ans_q, ans_d;
    logic               to_q, to_d, ready_q, ready_d, rv_q, rv_d;
    logic               rc_q, rc_d, rt_q, rt_d, over_q, over_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic               press_evt, ok;

    key_edge_sync u_submit (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .key_n    (submit_n),
        .press_evt(press_evt)
    );

    assign ok = !to_q && (ans_q == exp_q);

`ifdef NOT_NOT_SPEEDUP_EN
    localparam logic [TW-1:0] STEP     = TW'(TIMEOUT_CYCLES >> 3);
    localparam logic [TW-1:0] FLOOR_M1 = TW'((TIMEOUT_CYCLES >> 2) - 1);
    logic [TW-1:0] lim_q, lim_d;

    // limit is held as limit-1 so it compares directly against the timer
    assign lim_d = (state_q == JUDGE && ok)
                 ? ((lim_q >= FLOOR_M1 + STEP) ? lim_q - STEP : FLOOR_M1) : lim_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) lim_q <= LAST;
        else         lim_q <= lim_d;
    end

    assign lim_m1 = lim_q;
`else
    assign lim_m1 = LAST;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        exp_d   = exp_q;
        ans_d   = ans_q;
        to_d    = to_q;
        ready_d = ready_q;
        rv_d    = 1'b0;
        rc_d    = rc_q;
        rt_d    = rt_q;
        score_d = score_q;
        lives_d = lives_q;
        over_d  = over_q;
        case (state_q)
            IDLE: if (round_valid) begin
                exp_d   = expected;
                timer_d = '0;
                to_d    = 1'b0;
                ready_d = 1'b0;
                state_d = ARMED;
            end
            ARMED: if (press_evt) begin
                ans_d   = answer;
                state_d = JUDGE;
            end else if (timer_q == lim_m1) begin
                to_d    = 1'b1;
                state_d = JUDGE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            JUDGE: begin
                rv_d    = 1'b1;
                rc_d    = ok;
                rt_d    = to_q;
                score_d = (ok && score_q != '1) ? score_q + 1'b1 : score_q;
                lives_d = ok ? lives_q : lives_q - 1'b1;
                over_d  = (lives_d == 3'd0);
                ready_d = !over_d;
                state_d = over_d ? OVER : IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            timer_q <= '0;
            exp_q   <= '0;
            ans_q   <= '0;
            to_q    <= 1'b0;
            ready_q <= 1'b1;
            rv_q    <= 1'b0;
            rc_q    <= 1'b0;
            rt_q    <= 1'b0;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            exp_q   <= exp_d;
            ans_q   <= ans_d;
            to_q    <= to_d;
            ready_q <= ready_d;
            rv_q    <= rv_d;
            rc_q    <= rc_d;
            rt_q    <= rt_d;
            score_q <= score_d;
            lives_q <= lives_d;
            over_q  <= over_d;
        end
    end

    assign round_ready    = ready_q;
    assign result_valid   = rv_q;
    assign result_correct = rc_q;
    assign result_timeout = rt_q;
    assign score          = score_q;
    assign lives_left     = lives_q;
    assign game_over      = over_q;
endmodule

// File: tb/tb_not_not_judge.sv
// tb_not_not_judge: randomized rounds checked every cycle against an edge-indexed round model.
module tb_not_not_judge;
    localparam int T  = 16;
    localparam int SW = 8;
    localparam int L  = 3;

    logic          clk = 1'b0, resetn = 1'b0, round_valid = 1'b0, submit_n = 1'b1;
    logic [3:0]    expected = '0, answer = '0;
    logic          round_ready, result_valid, result_correct, result_timeout, game_over;
    logic [SW-1:0] score;
    logic [2:0]    lives_left;

    always #5 clk = ~clk;

    not_not_judge #(.TIMEOUT_CYCLES(T), .SCORE_W(SW), .LIVES(L)) dut (
        .CLOCK_50      (clk),
        .resetn        (resetn),
        .round_valid   (round_valid),
        .round_ready   (round_ready),
        .expected      (expected),
        .answer        (answer),
        .submit_n      (submit_n),
        .result_valid  (result_valid),
        .result_correct(result_correct),
        .result_timeout(result_timeout),
        .score         (score),
        .lives_left    (lives_left),
        .game_over     (game_over)
    );

    typedef struct {bit rv, rc, rt, rdy, go; int score, lives;} snap_t;
    snap_t RST = '{rv: 0, rc: 0, rt: 0, rdy: 1, go: 0, score: 0, lives: L};
    snap_t cur = '{rv: 0, rc: 0, rt: 0, rdy: 1, go: 0, score: 0, lives: L};
    snap_t m   = '{rv: 0, rc: 0, rt: 0, rdy: 1, go: 0, score: 0, lives: L};
    snap_t exp_at[int];
    int cyc = 0, n_cmp = 0, n_bad = 0, kh = 0, m_lim = T;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    // cyc counts edges; the snapshot keyed k holds what outputs must be after edge k
    initial forever begin
        @(posedge clk);
        #3;
        if (exp_at.exists(cyc)) begin
            cur = exp_at[cyc];
            exp_at.delete(cyc);
        end
        chk("result_valid", result_valid, cur.rv);
        chk("result_correct", result_correct, cur.rc);
        chk("result_timeout", result_timeout, cur.rt);
        chk("round_ready", round_ready, cur.rdy);
        chk("game_over", game_over, cur.go);
        chk("score", score, cur.score);
        chk("lives_left", lives_left, cur.lives);
        cur.rv = 0;
    end

    task automatic do_reset();
        int q[$];
        int k;
        k = cyc + 1;
        resetn = 1'b0;
        round_valid = 1'b0;
        submit_n = 1'b1;
        foreach (exp_at[i]) if (i >= k) q.push_back(i);
        foreach (q[j]) exp_at.delete(q[j]);
        m = RST;
        m_lim = T;
        exp_at[k] = RST;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        kh = cyc;
    endtask

    // A key low first sampled at edge f yields press_evt seen by the FSM at edge f+3;
    // it counts only if that edge lies in the armed window h+1 .. h+limit.
    task automatic run_round(input logic [3:0] e, input logic [3:0] a, input int t,
                             input bit ip, input int gap, input int rst_at, output int dur);
        int base, h, fi, hi, f, hd, r;
        bit pr, ok;
        snap_t s;
        fi = -100; hi = 0; f = -100; hd = 0;
        base = cyc + 1;
        if (ip) begin
            fi = (base > kh + 3) ? base : kh + 3;
            hi = 1 + int'($urandom % 8);
            kh = fi + hi;
        end
        h = base + gap;
        if (ip && h < fi + 3) h = fi + 3;
        pr = (t >= 0);
        if (pr) begin
            if (h + t - 2 < kh + 3) t = kh + 5 - h;
            pr = (t < m_lim);
        end
        if (pr) begin
            f = h + t - 2;
            hd = 1 + int'($urandom % 4);
            kh = f + hd;
            r = h + 1 + t;
        end else begin
            r = h + m_lim;
        end
        s = m;
        s.rdy = 0;
        exp_at[h] = s;
        ok = pr && (a == e);
        if (ok) begin
            if (m.score < 255) m.score++;
`ifdef NOT_NOT_SPEEDUP_EN
            m_lim = (m_lim - (T >> 3) < (T >> 2)) ? (T >> 2) : m_lim - (T >> 3);
`endif
        end else begin
            m.lives--;
        end
        m.rc = ok;
        m.rt = !pr;
        m.go = (m.lives == 0);
        m.rdy = !m.go;
        s = m;
        s.rv = 1;
        exp_at[r + 1] = s;
        expected = e;
        answer = a;
        dur = r - h;
        for (int k = cyc + 1; k <= r + 1; k++) begin
            if (rst_at > 0 && k == h + rst_at) begin
                do_reset();
                dur = -1;
                return;
            end
            round_valid = (k == h) || (k > h && $urandom % 4 == 0);
            submit_n = !((k >= fi && k < fi + hi) || (k >= f && k < f + hd));
            @(negedge clk);
        end
        round_valid = 1'b0;
        submit_n = 1'b1;
    endtask

    task automatic noise();
        repeat (30) begin
            round_valid = 1'($urandom % 2);
            submit_n = 1'($urandom % 2);
            answer = 4'($urandom);
            expected = 4'($urandom);
            @(negedge clk);
        end
        round_valid = 1'b0;
        submit_n = 1'b1;
    endtask

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog cyc=%0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, n, t;
        logic [3:0] e, a;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        kh = cyc;
        chk("rst_ready", round_ready, 1);
        chk("rst_lives", lives_left, 3);
        chk("rst_score", score, 0);
        chk("rst_over", game_over, 0);

        run_round(4'b0101, 4'b0101, 5, 0, 2, 0, d);
        chk("r1_valid", result_valid, 1);
        chk("r1_correct", result_correct, 1);
        chk("r1_score", score, 1);
        chk("r1_lives", lives_left, 3);
        chk("r1_ready", round_ready, 1);
        chk("r1_dur", d, 6);

        run_round(4'b1010, 4'b1011, 3, 0, 1, 0, d);
        chk("r2_correct", result_correct, 0);
        chk("r2_timeout", result_timeout, 0);
        chk("r2_lives", lives_left, 2);

        run_round(4'b0011, 4'b0011, -1, 1, 0, 0, d);
        chk("r3_timeout", result_timeout, 1);
        chk("r3_lives", lives_left, 1);
        chk("r3_dur", d, 16);

        run_round(4'b0110, 4'b0110, 15, 0, 1, 0, d);
        chk("r4_timeout", result_timeout, 0);
        chk("r4_correct", result_correct, 1);
        chk("r4_score", score, 2);
        chk("r4_dur", d, 16);

        do_reset();
        chk("rst2_score", score, 0);
        chk("rst2_lives", lives_left, 3);

`ifdef NOT_NOT_SPEEDUP_EN
        run_round(4'h3, 4'h3, 2, 0, 1, 0, d);
        run_round(4'h3, 4'h3, -1, 0, 1, 0, d);
        chk("sp_lim1", d, 14);
        repeat (5) run_round(4'h5, 4'h5, 1, 0, 0, 0, d);
        run_round(4'h3, 4'h3, -1, 0, 1, 0, d);
        chk("sp_lim6", d, 4);
        run_round(4'h7, 4'h7, 0, 0, 0, 0, d);
        run_round(4'h3, 4'h3, -1, 0, 1, 0, d);
        chk("sp_lim7", d, 4);
        do_reset();
`endif

        repeat (3) run_round(4'h9, 4'h6, 4, 0, 1, 0, d);
        chk("go_over", game_over, 1);
        chk("go_ready", round_ready, 0);
        noise();
        chk("go_over_hold", game_over, 1);
        chk("go_lives_hold", lives_left, 0);
        do_reset();
        chk("go_rst_score", score, 0);
        chk("go_rst_lives", lives_left, 3);

        run_round(4'hC, 4'hC, 2, 0, 0, 0, d);
        run_round(4'h1, 4'h2, 8, 0, 1, 4, d);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_ready", round_ready, 1);

        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (!m.go && n < 30) begin
                e = 4'($urandom);
                a = ($urandom % 2 == 0) ? e : e ^ 4'(1 + $urandom % 15);
                t = int'($urandom % 20) - 2;
                if (t < 0) t = -1;
                run_round(e, a, t, 1'($urandom % 2), int'($urandom % 5), 0, d);
                n++;
            end
            noise();
            do_reset();
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
